alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 4..32.
REQ-002 Parameter SIGNED_CMP, default 1: 1 means GT/LT/overflow use two's-complement; 0 means unsigned.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block accepts the transfer this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 op  input  4  opcode, encoded per alu_pkg.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_data  output  WIDTH  result.
REQ-012 out_flags  output  4  {illegal, ovf, neg, zero} for out_data.
REQ-013 sticky_ovf  output  1  set by any delivered ovf; cleared by clr_sticky.
REQ-014 clr_sticky  input  1  synchronous clear of sticky_ovf.

Function
REQ-015 Opcodes: 0 PASS_A, 1 INC_A, 2 DEC_A, 3 NOT_A, 4 NOR, 5 XOR, 6 XNOR, 7 GT, 8 LT, 9 EQ, 10 ADD, 11 SUB; 12..15 illegal.
REQ-016 GT/LT/EQ results are zero-extended 1 or 0 in bit 0; GT/LT follow SIGNED_CMP.
REQ-017 Illegal opcode: out_data=0, illegal=1, other flags=0.
REQ-018 Pipeline has 2 stages: S1 registers {a, b, op}; S2 registers the computed result and flags.
REQ-019 Transfer in: in_valid and in_ready both high at a clock edge; transfer out: out_valid and out_ready both high at a clock edge.
REQ-020 Latency is 2 cycles from input transfer to out_valid when unstalled; throughput is 1 per cycle.
REQ-021 S2 loads when S2 is empty or out_ready=1.
REQ-022 in_ready = !S1_valid or S2 loads this cycle; it is combinational from out_ready, with no combinational path from in_valid.
REQ-023 With out_valid=1 and out_ready=0, out_data and out_flags are held stable and no transfer is lost or duplicated.
REQ-024 Arithmetic wraps modulo 2^WIDTH; the carry-out is discarded.
REQ-025 ovf flag by mode:
- signed INC/DEC/ADD/SUB: signed overflow;
- unsigned: carry-out on INC/ADD, borrow on DEC/SUB;
- 0 for all other opcodes.
REQ-026 zero = (out_data==0); neg = out_data[WIDTH-1]; both are computed for every legal opcode.
REQ-027 sticky_ovf sets on an output transfer carrying ovf=1.
REQ-028 If clr_sticky and a set event occur in the same cycle, the set wins.

Reset
REQ-029 Reset values: both stage valids, out_valid, out_data, out_flags and sticky_ovf are 0; in_ready is 1 after release.
REQ-030 Reset asserted mid-operation discards all in-flight results with no partial output.

Configuration
REQ-031 Macro ALU_PIPE_SAT_EN defined: INC/DEC/ADD/SUB clamp to the mode's max/min on overflow; ovf is still reported.
REQ-032 Macro ALU_PIPE_SAT_EN undefined: those opcodes wrap per REQ-024.

Structure
REQ-033 Package alu_pkg holds:
- the opcode enum;
- the flag bit-index constants;
- the opcode count constant.
REQ-034 Sub-module alu_core (combinational, parameterised by WIDTH and SIGNED_CMP) computes result and flags; alu_pipe owns all registers and the handshake.

Verification
REQ-035 WIDTH=8, SIGNED_CMP=1, ADD a=0x7F b=0x01 -> out_data 0x80, ovf=1, neg=1, sticky_ovf=1 after transfer; 0x7F with ALU_PIPE_SAT_EN.
REQ-036 SIGNED_CMP=0, GT a=0x80 b=0x7F -> 0x01; SIGNED_CMP=1, same operands -> 0x00, zero=1.
REQ-037 Back-to-back stream of 10 ops, out_ready held 0 for cycles 3-6 -> all 10 results in order, none dropped or duplicated, and in_ready=0 while both stages are full.
REQ-038 op=13 -> out_data 0x00, out_flags 4'b1000.
REQ-039 rst_n pulsed low with 2 results in flight -> out_valid=0 immediately, and no stale result appears after release.
REQ-040 clr_sticky and an ovf transfer in the same cycle -> sticky_ovf=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag bit positions and opcode legality helper for the
// alu_pipe block and its combinational core.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_PASS_A = 4'd0,
        OP_INC_A  = 4'd1,
        OP_DEC_A  = 4'd2,
        OP_NOT_A  = 4'd3,
        OP_NOR    = 4'd4,
        OP_XOR    = 4'd5,
        OP_XNOR   = 4'd6,
        OP_GT     = 4'd7,
        OP_LT     = 4'd8,
        OP_EQ     = 4'd9,
        OP_ADD    = 4'd10,
        OP_SUB    = 4'd11
    } alu_op_e;

    localparam int OP_COUNT     = 12;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_NEG     = 1;
    localparam int FLAG_OVF     = 2;
    localparam int FLAG_ILLEGAL = 3;
    localparam int FLAG_W       = 4;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (int'(op) < OP_COUNT);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and {illegal, ovf, neg, zero} flags.
// Define ALU_PIPE_SAT_EN to clamp INC/DEC/ADD/SUB to the mode's range on overflow.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SIGNED_CMP = 1
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [3:0]        op,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags
);

    localparam bit SGN = (SIGNED_CMP != 0);
    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] SMAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0]   ONE_X = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0]   ext_a_s;
    logic [WIDTH:0]   ext_b_s;
    logic [WIDTH:0]   wide_s;
    logic [WIDTH-1:0] raw_s;
    logic [WIDTH-1:0] final_s;
    logic             ovf_s;
    logic             illegal_s;
    logic             gt_s;
    logic             lt_s;

    assign ext_a_s   = {1'b0, a};
    assign ext_b_s   = {1'b0, b};
    assign illegal_s = !op_is_legal(op);

    // Magnitude comparison in the configured number domain
    always_comb begin
        gt_s = 1'b0;
        lt_s = 1'b0;
        if (SGN) begin
            gt_s = ($signed(a) > $signed(b));
            lt_s = ($signed(a) < $signed(b));
        end else begin
            gt_s = (a > b);
            lt_s = (a < b);
        end
    end

    // Opcode decode; the extra top bit of wide_s is the unsigned carry/borrow
    always_comb begin
        wide_s = {(WIDTH+1){1'b0}};
        raw_s  = {WIDTH{1'b0}};
        ovf_s  = 1'b0;
        case (op)
            OP_PASS_A: raw_s = a;
            OP_INC_A: begin
                wide_s = ext_a_s + ONE_X;
                raw_s  = wide_s[WIDTH-1:0];
                ovf_s  = SGN ? (a == SMAX) : wide_s[WIDTH];
            end
            OP_DEC_A: begin
                wide_s = ext_a_s - ONE_X;
                raw_s  = wide_s[WIDTH-1:0];
                ovf_s  = SGN ? (a == SMIN) : wide_s[WIDTH];
            end
            OP_NOT_A:  raw_s = ~a;
            OP_NOR:    raw_s = ~(a | b);
            OP_XOR:    raw_s = a ^ b;
            OP_XNOR:   raw_s = ~(a ^ b);
            OP_GT:     raw_s = {{(WIDTH-1){1'b0}}, gt_s};
            OP_LT:     raw_s = {{(WIDTH-1){1'b0}}, lt_s};
            OP_EQ:     raw_s = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_ADD: begin
                wide_s = ext_a_s + ext_b_s;
                raw_s  = wide_s[WIDTH-1:0];
                ovf_s  = SGN ? ((a[MSB] == b[MSB]) && (wide_s[MSB] != a[MSB]))
                             : wide_s[WIDTH];
            end
            OP_SUB: begin
                wide_s = ext_a_s - ext_b_s;
                raw_s  = wide_s[WIDTH-1:0];
                ovf_s  = SGN ? ((a[MSB] != b[MSB]) && (wide_s[MSB] != a[MSB]))
                             : wide_s[WIDTH];
            end
            default: begin
                raw_s = {WIDTH{1'b0}};
                ovf_s = 1'b0;
            end
        endcase
    end

`ifdef ALU_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = SGN ? SMAX : {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] SAT_MIN = SGN ? SMIN : {WIDTH{1'b0}};

    logic sat_hi_s;

    // Only arithmetic opcodes raise ovf; signed overflow direction follows a's sign
    always_comb begin
        sat_hi_s = SGN ? !a[MSB] : ((op == OP_INC_A) || (op == OP_ADD));
        if (ovf_s) begin
            final_s = sat_hi_s ? SAT_MAX : SAT_MIN;
        end else begin
            final_s = raw_s;
        end
    end
`else
    assign final_s = raw_s;
`endif

    // Flag assembly; an illegal opcode forces a zero result with only illegal set
    always_comb begin
        flags  = {FLAG_W{1'b0}};
        result = {WIDTH{1'b0}};
        if (illegal_s) begin
            flags[FLAG_ILLEGAL] = 1'b1;
        end else begin
            result          = final_s;
            flags[FLAG_OVF]  = ovf_s;
            flags[FLAG_NEG]  = final_s[MSB];
            flags[FLAG_ZERO] = (final_s == {WIDTH{1'b0}});
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands, S2 holds result and flags.
// Saturating arithmetic is selected with the ALU_PIPE_SAT_EN macro (see alu_core).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SIGNED_CMP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_flags,
    output logic             sticky_ovf,
    input  logic             clr_sticky
);

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [3:0]       s1_op_r;
    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_data_r;
    logic [3:0]       s2_flags_r;
    logic             sticky_r;

    logic [WIDTH-1:0] core_result_s;
    logic [3:0]       core_flags_s;
    logic             s2_load_s;
    logic             out_fire_s;

    // S2 can take a new value when empty or being drained; in_ready never sees in_valid
    assign s2_load_s  = !s2_valid_r || out_ready;
    assign in_ready   = !s1_valid_r || s2_load_s;
    assign out_fire_s = s2_valid_r && out_ready;

    alu_core #(
        .WIDTH      (WIDTH),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_core (
        .a      (s1_a_r),
        .b      (s1_b_r),
        .op     (s1_op_r),
        .result (core_result_s),
        .flags  (core_flags_s)
    );

    // Stage 1: capture operands and opcode on an input transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_op_r    <= 4'd0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_a_r  <= a;
                s1_b_r  <= b;
                s1_op_r <= op;
            end
        end
    end

    // Stage 2: result register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= {WIDTH{1'b0}};
            s2_flags_r <= 4'd0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_data_r  <= core_result_s;
                s2_flags_r <= core_flags_s;
            end
        end
    end

    // Sticky overflow: a delivered ovf outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= 1'b0;
        end else if (out_fire_s && s2_flags_r[FLAG_OVF]) begin
            sticky_r <= 1'b1;
        end else if (clr_sticky) begin
            sticky_r <= 1'b0;
        end
    end

    assign out_valid  = s2_valid_r;
    assign out_data   = s2_data_r;
    assign out_flags  = s2_flags_r;
    assign sticky_ovf = sticky_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a signed (default) and an unsigned instance share
// stimulus; expectations follow ALU_PIPE_SAT_EN when it is defined.
module tb_alu_pipe;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic [3:0] f;
    } vec_t;

`ifdef ALU_PIPE_SAT_EN
    localparam logic [7:0] S_DEC80_D = 8'h80;  localparam logic [3:0] S_DEC80_F = 4'b0110;
    localparam logic [7:0] S_ADD7F_D = 8'h7F;  localparam logic [3:0] S_ADD7F_F = 4'b0100;
    localparam logic [7:0] U_ADDFF_D = 8'hFF;  localparam logic [3:0] U_ADDFF_F = 4'b0110;
    localparam logic [7:0] U_DEC00_D = 8'h00;  localparam logic [3:0] U_DEC00_F = 4'b0101;
`else
    localparam logic [7:0] S_DEC80_D = 8'h7F;  localparam logic [3:0] S_DEC80_F = 4'b0100;
    localparam logic [7:0] S_ADD7F_D = 8'h80;  localparam logic [3:0] S_ADD7F_F = 4'b0110;
    localparam logic [7:0] U_ADDFF_D = 8'h00;  localparam logic [3:0] U_ADDFF_F = 4'b0101;
    localparam logic [7:0] U_DEC00_D = 8'hFF;  localparam logic [3:0] U_DEC00_F = 4'b0110;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic       clr_sticky;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;

    logic       in_ready, out_valid, sticky_ovf;
    logic [7:0] out_data;
    logic [3:0] out_flags;
    logic       in_ready_u, out_valid_u, sticky_ovf_u;
    logic [7:0] out_data_u;
    logic [3:0] out_flags_u;

    logic [7:0] r_data, r_data_u;
    logic [3:0] r_flags, r_flags_u;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .SIGNED_CMP(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags), .sticky_ovf(sticky_ovf),
        .clr_sticky(clr_sticky)
    );

    alu_pipe #(.WIDTH(8), .SIGNED_CMP(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .a(a), .b(b), .op(op), .out_valid(out_valid_u), .out_ready(out_ready),
        .out_data(out_data_u), .out_flags(out_flags_u), .sticky_ovf(sticky_ovf_u),
        .clr_sticky(clr_sticky)
    );

    // One transaction into an empty pipe; returns at the negedge where the result shows
    task automatic run_one(input logic [3:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b);
        logic got;
        @(negedge clk);
        op = t_op; a = t_a; b = t_b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            if (out_valid) got = 1'b1;
            else @(negedge clk);
        end
        r_data = out_data; r_flags = out_flags;
        r_data_u = out_data_u; r_flags_u = out_flags_u;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL run_one_timeout op=%0d got out_valid=0 expected 1", t_op);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        a = 8'h00; b = 8'h00; op = 4'd0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
        checks++; if (out_flags !== 4'b0000) begin errors++; $display("FAIL rst_out_flags got=%b exp=0000", out_flags); end
        checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL rst_sticky got=%b exp=0", sticky_ovf); end
        checks++; if (out_valid_u !== 1'b0) begin errors++; $display("FAIL rst_out_valid_u got=%b exp=0", out_valid_u); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add_ovf();
        checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL add_sticky_pre got=%b exp=0", sticky_ovf); end
        run_one(4'd10, 8'h7F, 8'h01);
        checks++; if (r_data !== S_ADD7F_D) begin errors++; $display("FAIL add7f_data got=%h exp=%h", r_data, S_ADD7F_D); end
        checks++; if (r_flags !== S_ADD7F_F) begin errors++; $display("FAIL add7f_flags got=%b exp=%b", r_flags, S_ADD7F_F); end
        checks++; if (r_data_u !== 8'h80) begin errors++; $display("FAIL add7f_data_u got=%h exp=80", r_data_u); end
        checks++; if (r_flags_u !== 4'b0010) begin errors++; $display("FAIL add7f_flags_u got=%b exp=0010", r_flags_u); end
        @(posedge clk); @(negedge clk);
        checks++; if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL add_sticky_post got=%b exp=1", sticky_ovf); end
        checks++; if (sticky_ovf_u !== 1'b0) begin errors++; $display("FAIL add_sticky_u got=%b exp=0", sticky_ovf_u); end
    endtask

    task automatic test_ops();
        vec_t v[13];
        v[0]  = '{4'd0,  8'h5A, 8'h00, 8'h5A, 4'b0000};
        v[1]  = '{4'd1,  8'hFF, 8'h00, 8'h00, 4'b0001};
        v[2]  = '{4'd2,  8'h80, 8'h00, S_DEC80_D, S_DEC80_F};
        v[3]  = '{4'd3,  8'h0F, 8'h00, 8'hF0, 4'b0010};
        v[4]  = '{4'd4,  8'h0F, 8'hF0, 8'h00, 4'b0001};
        v[5]  = '{4'd5,  8'hAA, 8'h55, 8'hFF, 4'b0010};
        v[6]  = '{4'd6,  8'hAA, 8'hAA, 8'hFF, 4'b0010};
        v[7]  = '{4'd8,  8'h80, 8'h01, 8'h01, 4'b0000};
        v[8]  = '{4'd9,  8'h33, 8'h33, 8'h01, 4'b0000};
        v[9]  = '{4'd11, 8'h80, 8'h01, S_DEC80_D, S_DEC80_F};
        v[10] = '{4'd11, 8'h05, 8'h05, 8'h00, 4'b0001};
        v[11] = '{4'd13, 8'h12, 8'h34, 8'h00, 4'b1000};
        v[12] = '{4'd15, 8'hFF, 8'hFF, 8'h00, 4'b1000};
        for (int i = 0; i < 13; i++) begin
            run_one(v[i].op, v[i].a, v[i].b);
            checks++;
            if (r_data !== v[i].d) begin errors++; $display("FAIL ops_data[%0d] op=%0d got=%h exp=%h", i, v[i].op, r_data, v[i].d); end
            checks++;
            if (r_flags !== v[i].f) begin errors++; $display("FAIL ops_flags[%0d] op=%0d got=%b exp=%b", i, v[i].op, r_flags, v[i].f); end
        end
    endtask

    task automatic test_unsigned();
        run_one(4'd10, 8'hFF, 8'h01);
        checks++; if (r_data !== 8'h00 || r_flags !== 4'b0001) begin errors++; $display("FAIL uadd_signed got=%h/%b exp=00/0001", r_data, r_flags); end
        checks++; if (r_data_u !== U_ADDFF_D || r_flags_u !== U_ADDFF_F) begin errors++; $display("FAIL uadd_unsigned got=%h/%b exp=%h/%b", r_data_u, r_flags_u, U_ADDFF_D, U_ADDFF_F); end
        run_one(4'd2, 8'h00, 8'h00);
        checks++; if (r_data !== 8'hFF || r_flags !== 4'b0010) begin errors++; $display("FAIL udec_signed got=%h/%b exp=FF/0010", r_data, r_flags); end
        checks++; if (r_data_u !== U_DEC00_D || r_flags_u !== U_DEC00_F) begin errors++; $display("FAIL udec_unsigned got=%h/%b exp=%h/%b", r_data_u, r_flags_u, U_DEC00_D, U_DEC00_F); end
        run_one(4'd1, 8'hFF, 8'h00);
        checks++; if (r_data_u !== U_ADDFF_D || r_flags_u !== U_ADDFF_F) begin errors++; $display("FAIL uinc_unsigned got=%h/%b exp=%h/%b", r_data_u, r_flags_u, U_ADDFF_D, U_ADDFF_F); end
    endtask

    task automatic test_cmp();
        run_one(4'd7, 8'h80, 8'h7F);
        checks++; if (r_data !== 8'h00 || r_flags !== 4'b0001) begin errors++; $display("FAIL gt_signed got=%h/%b exp=00/0001", r_data, r_flags); end
        checks++; if (r_data_u !== 8'h01 || r_flags_u !== 4'b0000) begin errors++; $display("FAIL gt_unsigned got=%h/%b exp=01/0000", r_data_u, r_flags_u); end
        run_one(4'd8, 8'h80, 8'h7F);
        checks++; if (r_data !== 8'h01) begin errors++; $display("FAIL lt_signed got=%h exp=01", r_data); end
        checks++; if (r_data_u !== 8'h00) begin errors++; $display("FAIL lt_unsigned got=%h exp=00", r_data_u); end
    endtask

    task automatic test_sticky_clr();
        @(negedge clk); clr_sticky = 1'b1;
        @(negedge clk); clr_sticky = 1'b0;
        checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL sticky_clear got=%b exp=0", sticky_ovf); end
        clr_sticky = 1'b1;
        run_one(4'd10, 8'h7F, 8'h01);
        @(posedge clk); @(negedge clk);
        clr_sticky = 1'b0;
        checks++; if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got=%b exp=1", sticky_ovf); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] expq[10];
        int sent = 0, rcv = 0, cyc = 0, full_seen = 0;
        logic fire_in, fire_out;
        for (int i = 0; i < 10; i++) expq[i] = 8'(i * 3 + 1);
        while (rcv < 10 && cyc < 40) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 10);
            op = 4'd10; a = 8'(sent * 3); b = 8'h01;
            #1;
            checks++;
            if (in_ready !== ((sent - rcv) < 2 || out_ready)) begin
                errors++; $display("FAIL b2b_in_ready cyc=%0d got=%b inflight=%0d out_ready=%b", cyc, in_ready, sent - rcv, out_ready);
            end
            if ((sent - rcv) == 2 && !out_ready) full_seen++;
            if (out_valid) begin
                checks++;
                if (out_data !== expq[rcv]) begin errors++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", rcv, out_data, expq[rcv]); end
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            @(posedge clk);
            if (fire_in) sent++;
            if (fire_out) rcv++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (rcv != 10) begin errors++; $display("FAIL b2b_count got=%0d exp=10", rcv); end
        checks++; if (full_seen == 0) begin errors++; $display("FAIL b2b_full_stall got=%0d exp>0", full_seen); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_flight();
        int stale = 0;
        @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; op = 4'd10; a = 8'h01; b = 8'h01;
        @(posedge clk);
        @(negedge clk); a = 8'h02;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rf_pre got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_async got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rf_data got=%h exp=00", out_data); end
        checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL rf_sticky got=%b exp=0", sticky_ovf); end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL rf_stale got=%0d exp=0", stale); end
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_ops();
        test_unsigned();
        test_cmp();
        test_sticky_clr();
        test_back_to_back();
        test_reset_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
